// File: rtl/rst_cipher_pkg.sv
// ---------------------------------------------------------------------------
// rst_cipher_pkg
// Shared definitions for the Rotary Substitution Table (RST) cipher pair
// (rst_cipher / rst_decipher): table and key types, the FSM state type,
// character constants and the alphanumeric helper used by key checking.
// ---------------------------------------------------------------------------
package rst_cipher_pkg;

  localparam int CHAR_W    = 8;
  localparam int KEY_LEN   = 12;
  localparam int TABLE_LEN = 6;

  typedef logic [TABLE_LEN-1:0][CHAR_W-1:0] rst_table_t;
  typedef logic [KEY_LEN-1:0][CHAR_W-1:0]   rst_key_t;

  typedef enum logic {
    ST_NO_KEY = 1'b0,
    ST_READY  = 1'b1
  } rst_state_t;

  localparam logic [7:0] NUL_CHAR         = 8'h00;
  localparam logic [7:0] UPPERCASE_A_CHAR = 8'h41;
  localparam logic [7:0] LOWERCASE_A_CHAR = 8'h61;
  localparam logic [7:0] DIGIT_0_CHAR     = 8'h30;
  localparam logic [5:0] NUM_LETTERS      = 6'd26;

  // True for 0-9, A-Z and a-z; these are the only characters a key may hold.
  function automatic logic is_alnum(input logic [7:0] ch);
    return ((ch >= 8'h30) && (ch <= 8'h39)) ||
           ((ch >= 8'h41) && (ch <= 8'h5A)) ||
           ((ch >= 8'h61) && (ch <= 8'h7A));
  endfunction

endpackage

// File: rtl/rst_decipher_if.sv
// ---------------------------------------------------------------------------
// rst_decipher_if
// Key / ciphertext input bundle and plaintext / status output bundle of the
// RST decipher.
//   key, key_load          : key characters and install strobe
//   ctxt_valid, ctxt_str   : ciphertext pair {row_char, col_char}
//   ptxt_char, ptxt_ready  : decoded character and its 1-cycle valid pulse
//   err_invalid_ctxt       : pair not found in the table (1-cycle pulse)
//   err_invalid_key        : last key_load was rejected (sticky)
//   key_not_installed      : no valid key installed
// Modports: master drives key/ciphertext, slave (the decipher) drives results.
// ---------------------------------------------------------------------------
interface rst_decipher_if;
  import rst_cipher_pkg::*;

  rst_key_t    key;
  logic        key_load;
  logic        ctxt_valid;
  logic [15:0] ctxt_str;
  logic [7:0]  ptxt_char;
  logic        ptxt_ready;
  logic        err_invalid_ctxt;
  logic        err_invalid_key;
  logic        key_not_installed;

  modport master (
    output key, key_load, ctxt_valid, ctxt_str,
    input  ptxt_char, ptxt_ready, err_invalid_ctxt, err_invalid_key, key_not_installed
  );

  modport slave (
    input  key, key_load, ctxt_valid, ctxt_str,
    output ptxt_char, ptxt_ready, err_invalid_ctxt, err_invalid_key, key_not_installed
  );

endinterface

// File: rtl/rst_key_checker.sv
// ---------------------------------------------------------------------------
// rst_key_checker
// Combinational key validator shared by the RST cipher and decipher.
//   i_key    : 12 key characters
//   o_key_ok : 1 when every character is alphanumeric and all are distinct
// ---------------------------------------------------------------------------
module rst_key_checker
  import rst_cipher_pkg::*;
(
  input  rst_key_t i_key,
  output logic     o_key_ok
);

  // A repeated character would make the table lookup ambiguous, so every
  // pair of key characters is compared in addition to the alphabet check.
  always_comb begin
    o_key_ok = 1'b1;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (!is_alnum(i_key[i])) begin
        o_key_ok = 1'b0;
      end
      for (int j = i + 1; j < KEY_LEN; j++) begin
        if (i_key[i] == i_key[j]) begin
          o_key_ok = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rst_decipher.sv
// ---------------------------------------------------------------------------
// rst_decipher
// Decryption end of the RST cipher. Each ciphertext pair {row_char, col_char}
// is located in the 6x6 table built from the key and mapped back to one of
// A-Z / 0-9; after every successfully decoded pair the row and column tables
// rotate right by one, mirroring rst_cipher.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rst_decipher_if.slave (key/ciphertext in, plaintext/status out)
// Build option: RST_DECIPHER_LOWERCASE_EN makes letters decode to a-z
// instead of A-Z; digits are unaffected.
// ---------------------------------------------------------------------------
module rst_decipher
  import rst_cipher_pkg::*;
(
  input logic           clk,
  input logic           rst,
  rst_decipher_if.slave bus
);

`ifdef RST_DECIPHER_LOWERCASE_EN
  localparam logic [7:0] LETTER_BASE = LOWERCASE_A_CHAR;
`else
  localparam logic [7:0] LETTER_BASE = UPPERCASE_A_CHAR;
`endif

  rst_state_t r_state;
  rst_table_t r_rowTable;
  rst_table_t r_colTable;
  logic [7:0] r_ptxtChar;
  logic       r_ptxtReady;
  logic       r_errInvalidCtxt;
  logic       r_errInvalidKey;
  logic       r_keyNotInstalled;

  logic       w_keyOk;
  rst_table_t w_installRows;
  rst_table_t w_installCols;
  logic       w_rowHit;
  logic       w_colHit;
  logic [2:0] w_rowIdx;
  logic [2:0] w_colIdx;
  logic [5:0] w_idx;
  logic [7:0] w_decodedChar;

  rst_key_checker u_keyChecker (
    .i_key    (bus.key),
    .o_key_ok (w_keyOk)
  );

  // Rows take the odd key positions and columns the even ones, interleaved
  // from both ends: R = k11,k1,k9,k3,k7,k5 and C = k10,k0,k8,k2,k6,k4.
  // Element 0 sits at the right end of each concatenation.
  assign w_installRows = {bus.key[5], bus.key[7], bus.key[3],
                          bus.key[9], bus.key[1], bus.key[11]};
  assign w_installCols = {bus.key[4], bus.key[6], bus.key[2],
                          bus.key[8], bus.key[0], bus.key[10]};

  // Two 6-way match encoders. Key characters are distinct, so at most one
  // entry of each table can hit.
  always_comb begin
    w_rowHit = 1'b0;
    w_rowIdx = 3'd0;
    w_colHit = 1'b0;
    w_colIdx = 3'd0;
    for (int i = 0; i < TABLE_LEN; i++) begin
      if (r_rowTable[i] == bus.ctxt_str[15:8]) begin
        w_rowHit = 1'b1;
        w_rowIdx = 3'(i);
      end
      if (r_colTable[i] == bus.ctxt_str[7:0]) begin
        w_colHit = 1'b1;
        w_colIdx = 3'(i);
      end
    end
  end

  // Cell index 0..25 are letters, 26..35 are digits.
  always_comb begin
    w_idx = (6'(w_rowIdx) * 6'd6) + 6'(w_colIdx);
    if (w_idx < NUM_LETTERS) begin
      w_decodedChar = LETTER_BASE + {2'b00, w_idx};
    end else begin
      w_decodedChar = DIGIT_0_CHAR + {2'b00, w_idx - NUM_LETTERS};
    end
  end

  // Control FSM with the table registers and all outputs registered.
  // key_load takes priority over a pair arriving in the same cycle; a
  // decoded pair uses the current table and the rotation lands afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= ST_NO_KEY;
      r_rowTable        <= '0;
      r_colTable        <= '0;
      r_ptxtChar        <= NUL_CHAR;
      r_ptxtReady       <= 1'b0;
      r_errInvalidCtxt  <= 1'b0;
      r_errInvalidKey   <= 1'b0;
      r_keyNotInstalled <= 1'b1;
    end else begin
      r_ptxtReady      <= 1'b0;
      r_errInvalidCtxt <= 1'b0;
      if (bus.key_load) begin
        if (w_keyOk) begin
          r_state           <= ST_READY;
          r_rowTable        <= w_installRows;
          r_colTable        <= w_installCols;
          r_errInvalidKey   <= 1'b0;
          r_keyNotInstalled <= 1'b0;
        end else begin
          r_state           <= ST_NO_KEY;
          r_rowTable        <= '0;
          r_colTable        <= '0;
          r_errInvalidKey   <= 1'b1;
          r_keyNotInstalled <= 1'b1;
        end
      end else if ((r_state == ST_READY) && bus.ctxt_valid) begin
        if (w_rowHit && w_colHit) begin
          r_ptxtChar  <= w_decodedChar;
          r_ptxtReady <= 1'b1;
          r_rowTable  <= {r_rowTable[4:0], r_rowTable[5]};
          r_colTable  <= {r_colTable[4:0], r_colTable[5]};
        end else begin
          r_errInvalidCtxt <= 1'b1;
        end
      end
    end
  end

  assign bus.ptxt_char         = r_ptxtChar;
  assign bus.ptxt_ready        = r_ptxtReady;
  assign bus.err_invalid_ctxt  = r_errInvalidCtxt;
  assign bus.err_invalid_key   = r_errInvalidKey;
  assign bus.key_not_installed = r_keyNotInstalled;

endmodule

// File: tb/tb_rst_decipher.sv
// ---------------------------------------------------------------------------
// tb_rst_decipher
// Self-checking bench for rst_decipher: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a cell-index / rotation-count model of the cipher.
// ---------------------------------------------------------------------------
module tb_rst_decipher;

`ifdef RST_DECIPHER_LOWERCASE_EN
  localparam logic [7:0] LETTER_BASE = 8'h61;
`else
  localparam logic [7:0] LETTER_BASE = 8'h41;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  bit   compareEn;

  rst_decipher_if bus ();

  rst_decipher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Key positions feeding row slot i and column slot i of a fresh table.
  int rowSel [6] = '{11, 1, 9, 3, 7, 5};
  int colSel [6] = '{10, 0, 8, 2, 6, 4};

  // Model state: installed key, number of rotations since install, and the
  // values the outputs must show after the most recent clock edge.
  logic [95:0] mKey;
  int          mRot;
  bit          mInstalled;
  logic [7:0]  expChar;
  logic        expReady;
  logic        expErrCtxt;
  logic        expErrKey;
  logic        expNotInst;

  logic [95:0] curKey;

  function automatic bit isAlnumChar(logic [7:0] c);
    return (c >= 8'd48 && c <= 8'd57) || (c >= 8'd65 && c <= 8'd90) ||
           (c >= 8'd97 && c <= 8'd122);
  endfunction

  function automatic bit modelKeyValid(logic [95:0] k);
    logic [11:0][7:0] kk;
    kk = k;
    for (int i = 0; i < 12; i++) begin
      if (!isAlnumChar(kk[i])) return 1'b0;
      for (int j = 0; j < 12; j++) begin
        if (i != j && kk[i] == kk[j]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  // Install-time position of a character in the row or column table, -1 if absent.
  function automatic int findPos(logic [95:0] k, bit isRow, logic [7:0] ch);
    logic [11:0][7:0] kk;
    kk = k;
    for (int i = 0; i < 6; i++) begin
      if (kk[isRow ? rowSel[i] : colSel[i]] == ch) return i;
    end
    return -1;
  endfunction

  function automatic logic [7:0] idxToChar(int idx);
    if (idx < 26) return 8'(int'(LETTER_BASE) + idx);
    return 8'(48 + idx - 26);
  endfunction

  // Uppercase literal adjusted for the letter-case build option.
  function automatic logic [7:0] lit(logic [7:0] c);
    if (c >= 8'd65 && c <= 8'd90) return 8'(int'(c) - 65 + int'(LETTER_BASE));
    return c;
  endfunction

  // Ciphertext for plaintext cell p after rot rotations: a character that
  // started in slot s sits in slot (s+rot)%6, so slot p/6 holds the one that
  // started at (p/6-rot)%6.
  function automatic logic [15:0] encryptCell(logic [95:0] k, int p, int rot);
    logic [11:0][7:0] kk;
    kk = k;
    return {kk[rowSel[(p / 6 - rot + 6) % 6]], kk[colSel[(p % 6 - rot + 6) % 6]]};
  endfunction

  function automatic logic [95:0] randomValidKey();
    string       alnum;
    logic [11:0][7:0] k;
    logic [7:0]  c;
    bit          dup;
    int          n;
    alnum = "0123456789ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz";
    k = '0;
    n = 0;
    while (n < 12) begin
      c = alnum[$urandom_range(0, 61)];
      dup = 1'b0;
      for (int j = 0; j < n; j++) begin
        if (k[j] == c) dup = 1'b1;
      end
      if (!dup) begin
        k[n] = c;
        n++;
      end
    end
    return k;
  endfunction

  // Behavioural reference: reacts to the asynchronous reset immediately and
  // otherwise evaluates the inputs present at each rising edge.
  initial begin : model
    int r0;
    int c0;
    mKey = '0; mRot = 0; mInstalled = 1'b0;
    expChar = 8'h00; expReady = 1'b0; expErrCtxt = 1'b0;
    expErrKey = 1'b0; expNotInst = 1'b1;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mRot = 0; mInstalled = 1'b0;
        expChar = 8'h00; expReady = 1'b0; expErrCtxt = 1'b0;
        expErrKey = 1'b0; expNotInst = 1'b1;
      end else begin
        expReady = 1'b0;
        expErrCtxt = 1'b0;
        if (bus.key_load) begin
          if (modelKeyValid(bus.key)) begin
            mKey = bus.key; mRot = 0; mInstalled = 1'b1;
            expErrKey = 1'b0; expNotInst = 1'b0;
          end else begin
            mInstalled = 1'b0; expErrKey = 1'b1; expNotInst = 1'b1;
          end
        end else if (bus.ctxt_valid && mInstalled) begin
          r0 = findPos(mKey, 1'b1, bus.ctxt_str[15:8]);
          c0 = findPos(mKey, 1'b0, bus.ctxt_str[7:0]);
          if (r0 >= 0 && c0 >= 0) begin
            expChar  = idxToChar(6 * ((r0 + mRot) % 6) + ((c0 + mRot) % 6));
            expReady = 1'b1;
            mRot     = (mRot + 1) % 6;
          end else begin
            expErrCtxt = 1'b1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every falling edge, all outputs are compared with the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (compareEn) begin
        checkOutput("cmp.ptxt_char", bus.ptxt_char, expChar);
        checkOutput("cmp.ptxt_ready", 8'(bus.ptxt_ready), 8'(expReady));
        checkOutput("cmp.err_invalid_ctxt", 8'(bus.err_invalid_ctxt), 8'(expErrCtxt));
        checkOutput("cmp.err_invalid_key", 8'(bus.err_invalid_key), 8'(expErrKey));
        checkOutput("cmp.key_not_installed", 8'(bus.key_not_installed), 8'(expNotInst));
      end
    end
  end

  // Drives one cycle of inputs (called just after a rising edge) and returns
  // just after the edge that samples them, so outputs reflect this cycle.
  task automatic applyStimulus(input bit load, input logic [95:0] k, input bit valid,
                               input logic [15:0] str);
    bus.key_load   = load;
    bus.key        = k;
    bus.ctxt_valid = valid;
    bus.ctxt_str   = str;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, 16'h0000);
  endtask

  task automatic checkPair(input string name, input logic [15:0] pair, input logic [7:0] ch);
    applyStimulus(1'b0, '0, 1'b1, pair);
    checkOutput({name, ".char"}, bus.ptxt_char, lit(ch));
    checkOutput({name, ".ready"}, 8'(bus.ptxt_ready), 8'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] time limit");
  end

  initial begin : stimulus
    logic [95:0] keyHello;
    logic [95:0] keyRt;
    logic [15:0] pairs [5];
    logic [7:0]  hello [5];
    logic [11:0][7:0] ck;
    int op;

    checks = 0; errors = 0; compareEn = 1'b0;
    keyHello = "ABCDEFGHIJKL";
    keyRt    = "0123456789ab";
    curKey   = keyHello;
    pairs = '{"KL", "GJ", "GJ", "ED", "EF"};
    hello = '{"H", "E", "L", "L", "O"};
    rst = 1'b0;
    bus.key_load = 1'b0; bus.key = '0; bus.ctxt_valid = 1'b0; bus.ctxt_str = '0;

    // Power-on reset values
    #2 rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset.ptxt_char", bus.ptxt_char, 8'h00);
    checkOutput("reset.ptxt_ready", 8'(bus.ptxt_ready), 8'd0);
    checkOutput("reset.err_invalid_ctxt", 8'(bus.err_invalid_ctxt), 8'd0);
    checkOutput("reset.err_invalid_key", 8'(bus.err_invalid_key), 8'd0);
    checkOutput("reset.key_not_installed", 8'(bus.key_not_installed), 8'd1);
    rst = 1'b0;
    compareEn = 1'b1;

    // Pair before any key is ignored
    applyStimulus(1'b0, '0, 1'b1, "KL");
    checkOutput("nokey.ready", 8'(bus.ptxt_ready), 8'd0);
    checkOutput("nokey.err_ctxt", 8'(bus.err_invalid_ctxt), 8'd0);

    // HELLO with a back-to-back stream; the model is pinned too
    applyStimulus(1'b1, keyHello, 1'b0, 16'h0000);
    checkOutput("t1.key_not_installed", 8'(bus.key_not_installed), 8'd0);
    for (int i = 0; i < 5; i++) begin
      checkPair($sformatf("t1.pair%0d", i), pairs[i], hello[i]);
      checkOutput($sformatf("t1.model%0d", i), expChar, lit(hello[i]));
    end
    idle();
    checkOutput("t1.idle.ready", 8'(bus.ptxt_ready), 8'd0);
    checkOutput("t1.idle.hold", bus.ptxt_char, lit("O"));

    // Rejected keys
    applyStimulus(1'b1, "ABCDEFGHDDKL", 1'b0, 16'h0000);
    checkOutput("t2.dup.err_key", 8'(bus.err_invalid_key), 8'd1);
    checkOutput("t2.dup.not_inst", 8'(bus.key_not_installed), 8'd1);
    checkOutput("t2.model.err_key", 8'(expErrKey), 8'd1);
    applyStimulus(1'b1, "ABC?*-.HIJKL", 1'b0, 16'h0000);
    checkOutput("t2.sym.err_key", 8'(bus.err_invalid_key), 8'd1);
    checkOutput("t2.sym.not_inst", 8'(bus.key_not_installed), 8'd1);
    applyStimulus(1'b0, '0, 1'b1, "KL");
    checkOutput("t2.pair.ready", 8'(bus.ptxt_ready), 8'd0);
    checkOutput("t2.pair.err_key_held", 8'(bus.err_invalid_key), 8'd1);

    // Unknown pair does not rotate the table
    applyStimulus(1'b1, keyHello, 1'b0, 16'h0000);
    checkOutput("t3.err_key_clear", 8'(bus.err_invalid_key), 8'd0);
    applyStimulus(1'b0, '0, 1'b1, "ZZ");
    checkOutput("t3.zz.err_ctxt", 8'(bus.err_invalid_ctxt), 8'd1);
    checkOutput("t3.zz.ready", 8'(bus.ptxt_ready), 8'd0);
    checkOutput("t3.zz.hold", bus.ptxt_char, lit("O"));
    checkPair("t3.kl", "KL", "H");
    checkOutput("t3.kl.err_ctxt", 8'(bus.err_invalid_ctxt), 8'd0);

    // Round trip of all 36 symbols through the rotating table
    applyStimulus(1'b1, keyRt, 1'b0, 16'h0000);
    curKey = keyRt;
    for (int p = 0; p < 36; p++) begin
      checkPair($sformatf("t4.p%0d", p), encryptCell(keyRt, p, p % 6),
                (p < 26) ? 8'(65 + p) : 8'(48 + p - 26));
    end
    idle();

    // Asynchronous reset mid-stream
    applyStimulus(1'b1, keyHello, 1'b0, 16'h0000);
    curKey = keyHello;
    checkPair("t5.p0", "KL", "H");
    checkPair("t5.p1", "GJ", "E");
    checkPair("t5.p2", "GJ", "L");
    bus.ctxt_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("t5.rst.ptxt_char", bus.ptxt_char, 8'h00);
    checkOutput("t5.rst.ready", 8'(bus.ptxt_ready), 8'd0);
    checkOutput("t5.rst.not_inst", 8'(bus.key_not_installed), 8'd1);
    checkOutput("t5.rst.err_key", 8'(bus.err_invalid_key), 8'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b1, keyHello, 1'b0, 16'h0000);
    checkPair("t5.reload", "KL", "H");

    // key_load wins over a simultaneous pair
    applyStimulus(1'b1, keyHello, 1'b1, "GJ");
    checkOutput("t6.ready", 8'(bus.ptxt_ready), 8'd0);
    checkOutput("t6.not_inst", 8'(bus.key_not_installed), 8'd0);
    checkPair("t6.kl", "KL", "H");
    idle();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      op = $urandom_range(0, 99);
      if (op < 2) begin
        bus.key_load = 1'b0; bus.ctxt_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end else if (op < 7) begin
        curKey = randomValidKey();
        applyStimulus(1'b1, curKey, 1'($urandom_range(0, 1)), 16'($urandom));
      end else if (op < 9) begin
        applyStimulus(1'b1, {$urandom, $urandom, $urandom}, 1'b0, 16'h0000);
      end else if (op < 75) begin
        ck = curKey;
        applyStimulus(1'b0, '0, 1'b1,
                      {($urandom_range(0, 9) == 0) ? 8'($urandom) : ck[rowSel[$urandom_range(0, 5)]],
                       ($urandom_range(0, 9) == 0) ? 8'($urandom) : ck[colSel[$urandom_range(0, 5)]]});
      end else if (op < 85) begin
        applyStimulus(1'b0, '0, 1'b1, 16'($urandom));
      end else begin
        idle();
      end
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
